alu_seq_unit: RTL
=================

# alu_seq_unit

Parametrised, handshaked ALU with integrated RV32-style operation decode. Accepts an aluop/funct3/funct7 triple and two XLEN-bit operands, decodes the operation, executes it (single-cycle logic/arith; iterative shifts and multiply), and holds the result until the consumer takes it. Sits in the execute stage between the main decoder and the writeback/branch logic. It is the multi-cycle, width-generic successor of the combinational ALU-control decoder.

## Interface
- XLEN, 32, datapath width; power of two, >= 8
- SHIFT_STEP, 1, bit positions shifted per cycle; power of two, 1..XLEN/2
- MUL_EN, 1, 1 enables MUL (funct7=0000001, funct3=000); 0 makes it illegal
- clk  in  1  clock; all state changes on rising edge
- reset  in  1  synchronous, active-high
- in_valid  in  1  operation offered
- in_ready  out  1  unit can accept (high only in IDLE)
- aluop  in  2  00 add, 01 sub, 10 R-type, 11 I-type
- funct3  in  3  instruction funct3
- funct7  in  7  instruction funct7 (for I-type: imm[11:5])
- a  in  XLEN  operand 1
- b  in  XLEN  operand 2 (shift amount = b[log2(XLEN)-1:0])
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- result  out  XLEN  operation result
- zero  out  1  result == 0
- illegal  out  1  decoded operation was illegal (result forced to 0)

## Operation
- States: IDLE, SHIFT, MUL, DONE. Accept = in_valid && in_ready; operands and decoded op latched on accept.
- Decode, aluop 00: ADD. 01: SUB. funct fields ignored.
- aluop 10, funct7=0000000: funct3 000 ADD, 001 SLL, 010 SLT, 011 SLTU, 100 XOR, 101 SRL, 110 OR, 111 AND.
- aluop 10, funct7=0100000: 000 SUB, 101 SRA; other funct3 illegal.
- aluop 10, funct7=0000001: 000 MUL if MUL_EN, else illegal; other funct3 illegal. Any other funct7 illegal.
- aluop 11: 000 ADD, 010 SLT, 011 SLTU, 100 XOR, 110 OR, 111 AND (funct7 ignored); 001 SLL only if funct7=0000000; 101 SRL if funct7=0000000, SRA if 0100000; otherwise illegal.
- Arithmetic modulo 2^XLEN, no overflow flag. SLT signed, SLTU unsigned; result zero-extended 0/1. MUL returns low XLEN bits of the product (sign-independent).
- Single-cycle ops and illegal: IDLE -> DONE on accept.
- Shifts: shamt=0 -> DONE directly; else IDLE -> SHIFT, each cycle shifts by min(SHIFT_STEP, remaining), SRA fills with original sign bit; SHIFT -> DONE when remaining reaches 0.
- MUL: IDLE -> MUL, shift-add one multiplier bit per cycle, exactly XLEN iterations, then DONE.
- DONE: out_valid=1, result/zero/illegal stable; on out_ready -> IDLE.

## Timing
- Reset (any state, including mid-SHIFT/MUL): next edge state=IDLE, out_valid=0, result=0, zero=0, illegal=0; in-flight op discarded. in_ready=0 while reset asserted, 1 in the first cycle after deassertion.
- Latency (accept edge to out_valid high): single-cycle/illegal 1; shift 1+ceil(shamt/SHIFT_STEP); MUL 1+XLEN.
- in_ready low from the accept edge until the edge completing the output handshake; max throughput one op per 2 cycles.
- out_valid held with stable outputs under backpressure; drops the cycle after out_valid && out_ready.
- in_valid while in_ready=0 is ignored (no queuing); inputs need only be valid in the accept cycle.

## Test plan
- Reset then ADD a=0xFFFFFFFF, b=1 (aluop 00) -> out_valid 1 cycle later, result=0, zero=1, illegal=0; SUB a=5,b=5 (aluop 01) -> result=0, zero=1.
- R-type SLT vs SLTU a=0xFFFFFFFF, b=1 -> SLT result=1, SLTU result=0.
- SRA a=0x80000000, b=4, SHIFT_STEP=1 -> result=0xF8000000 after 5 cycles; same with SHIFT_STEP=4 -> 2 cycles; shamt=0 -> result=a after 1 cycle.
- MUL a=0x00010003, b=0x00020005 (XLEN=32) -> result=0x000B000F after 33 cycles; with MUL_EN=0 -> illegal=1, result=0 after 1 cycle.
- Illegal: aluop 10, funct7=0100000, funct3=111 -> illegal=1, result=0, zero=1; out_ready held low 10 cycles -> outputs stable, in_ready=0 throughout, in_valid pulses ignored.
- Reset asserted on cycle 10 of a MUL -> next cycle out_valid=0, result=0; fresh ADD afterwards completes normally in 1 cycle.

Source files
------------

// File: rtl/alu_seq_if.sv
`default_nettype none
// ============================================================================
// Module      : alu_seq_if
// Description : Operation-request / result handshake bundle for alu_seq_unit.
// Revision    : 1.0  initial release
// ============================================================================
interface alu_seq_if #(
    parameter int XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [1:0]      aluop;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] result;
    logic            zero;
    logic            illegal;

    modport master (
        output in_valid, aluop, funct3, funct7, a, b, out_ready,
        input  in_ready, out_valid, result, zero, illegal
    );

    modport slave (
        input  in_valid, aluop, funct3, funct7, a, b, out_ready,
        output in_ready, out_valid, result, zero, illegal
    );
endinterface
`default_nettype wire

// File: rtl/alu_seq_unit.sv
`default_nettype none
// ============================================================================
// Module      : alu_seq_unit
// Description : Handshaked RV32-style ALU with decode, iterative shift/multiply.
// Revision    : 1.0  initial release
// ============================================================================
module alu_seq_unit #(
    parameter int XLEN       = 32,
    parameter int SHIFT_STEP = 1,
    parameter int MUL_EN     = 1
) (
    input  wire logic  clk,
    input  wire logic  reset,
    alu_seq_if.slave   bus
);
    localparam int SHW = $clog2(XLEN);
    localparam logic [SHW-1:0] c_step     = SHW'(SHIFT_STEP);
    localparam logic [SHW-1:0] c_mul_last = SHW'(XLEN - 1);
    localparam logic [6:0]     c_f7_base  = 7'b0000000;
    localparam logic [6:0]     c_f7_alt   = 7'b0100000;
    localparam logic [6:0]     c_f7_mul   = 7'b0000001;

    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_MUL, S_DONE} state_t;
    typedef enum logic [3:0] {
        OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU, OP_XOR,
        OP_SRL, OP_SRA, OP_OR, OP_AND, OP_MUL, OP_ILL
    } op_t;

    state_t          r_state, w_next;
    op_t             w_op, r_op;
    logic [XLEN-1:0] r_a, r_b, r_acc, r_result;
    logic [SHW-1:0]  r_rem, r_cnt;
    logic            r_zero, r_illegal;
    logic            w_in_ready, w_out_valid, w_accept, w_is_shift;
    logic [SHW-1:0]  w_shamt, w_step, w_rem_next;
    logic [XLEN-1:0] w_alu, w_shifted, w_mul_acc;

    always_comb begin
        w_op = OP_ILL;
        case (bus.aluop)
            2'b00: w_op = OP_ADD;
            2'b01: w_op = OP_SUB;
            2'b10: begin
                if (bus.funct7 == c_f7_base) begin
                    case (bus.funct3)
                        3'b000:  w_op = OP_ADD;
                        3'b001:  w_op = OP_SLL;
                        3'b010:  w_op = OP_SLT;
                        3'b011:  w_op = OP_SLTU;
                        3'b100:  w_op = OP_XOR;
                        3'b101:  w_op = OP_SRL;
                        3'b110:  w_op = OP_OR;
                        default: w_op = OP_AND;
                    endcase
                end else if (bus.funct7 == c_f7_alt) begin
                    if (bus.funct3 == 3'b000)      w_op = OP_SUB;
                    else if (bus.funct3 == 3'b101) w_op = OP_SRA;
                end else if (bus.funct7 == c_f7_mul && bus.funct3 == 3'b000 && MUL_EN != 0) begin
                    w_op = OP_MUL;
                end
            end
            default: begin
                // I-type: funct7 is immediate bits and matters only for shifts
                case (bus.funct3)
                    3'b000:  w_op = OP_ADD;
                    3'b001:  if (bus.funct7 == c_f7_base) w_op = OP_SLL;
                    3'b010:  w_op = OP_SLT;
                    3'b011:  w_op = OP_SLTU;
                    3'b100:  w_op = OP_XOR;
                    3'b101: begin
                        if (bus.funct7 == c_f7_base)     w_op = OP_SRL;
                        else if (bus.funct7 == c_f7_alt) w_op = OP_SRA;
                    end
                    3'b110:  w_op = OP_OR;
                    default: w_op = OP_AND;
                endcase
            end
        endcase
    end

    assign w_shamt    = bus.b[SHW-1:0];
    assign w_is_shift = (w_op == OP_SLL) || (w_op == OP_SRL) || (w_op == OP_SRA);

    // Shift ops yield the unshifted operand here so shamt=0 completes directly
    always_comb begin
        w_alu = '0;
        case (w_op)
            OP_ADD:  w_alu = bus.a + bus.b;
            OP_SUB:  w_alu = bus.a - bus.b;
            OP_SLT:  w_alu = {{(XLEN-1){1'b0}}, $signed(bus.a) < $signed(bus.b)};
            OP_SLTU: w_alu = {{(XLEN-1){1'b0}}, bus.a < bus.b};
            OP_XOR:  w_alu = bus.a ^ bus.b;
            OP_OR:   w_alu = bus.a | bus.b;
            OP_AND:  w_alu = bus.a & bus.b;
            OP_SLL, OP_SRL, OP_SRA: w_alu = bus.a;
            default: w_alu = '0;
        endcase
    end

    assign w_step     = (r_rem < c_step) ? r_rem : c_step;
    assign w_rem_next = r_rem - w_step;
    assign w_mul_acc  = r_acc + (r_b[0] ? r_a : '0);

    always_comb begin
        w_shifted = r_a >> w_step;
        if (r_op == OP_SLL)      w_shifted = r_a << w_step;
        else if (r_op == OP_SRA) w_shifted = $signed(r_a) >>> w_step;
    end

    assign w_accept = bus.in_valid && w_in_ready;

    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next      = r_state;
        w_in_ready  = 1'b0;
        w_out_valid = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_in_ready = !reset;
                if (w_accept) begin
                    if (w_is_shift && w_shamt != '0) w_next = S_SHIFT;
                    else if (w_op == OP_MUL)         w_next = S_MUL;
                    else                             w_next = S_DONE;
                end
            end
            S_SHIFT: if (w_rem_next == '0) w_next = S_DONE;
            S_MUL:   if (r_cnt == c_mul_last) w_next = S_DONE;
            default: begin
                w_out_valid = 1'b1;
                if (bus.out_ready) w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_op      <= OP_ILL;
            r_a       <= '0;
            r_b       <= '0;
            r_acc     <= '0;
            r_rem     <= '0;
            r_cnt     <= '0;
            r_result  <= '0;
            r_zero    <= 1'b0;
            r_illegal <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: if (w_accept) begin
                    r_op      <= w_op;
                    r_a       <= bus.a;
                    r_b       <= bus.b;
                    r_acc     <= '0;
                    r_rem     <= w_shamt;
                    r_cnt     <= '0;
                    r_result  <= w_alu;
                    r_zero    <= (w_alu == '0);
                    r_illegal <= (w_op == OP_ILL);
                end
                S_SHIFT: begin
                    r_a      <= w_shifted;
                    r_rem    <= w_rem_next;
                    r_result <= w_shifted;
                    r_zero   <= (w_shifted == '0);
                end
                S_MUL: begin
                    r_acc    <= w_mul_acc;
                    r_a      <= r_a << 1;
                    r_b      <= r_b >> 1;
                    r_cnt    <= r_cnt + 1'b1;
                    r_result <= w_mul_acc;
                    r_zero   <= (w_mul_acc == '0);
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = w_out_valid;
    assign bus.result    = r_result;
    assign bus.zero      = r_zero;
    assign bus.illegal   = r_illegal;
endmodule
`default_nettype wire
